// File: rtl/sine_wave_analyzer.sv
// Measures period, peaks and amplitude of an offset-binary sine stream.
// Uses hysteresis-qualified rising midline crossings and flags lock on matching periods.
module sine_wave_analyzer #(
    parameter int DW    = 16,
    parameter int MID   = 1000,
    parameter int HYST  = 50,
    parameter int CNT_W = 12,
    parameter int TOL   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_sample,
    output logic             out_valid,
    output logic [CNT_W-1:0] period,
    output logic [DW-1:0]    peak_max,
    output logic [DW-1:0]    peak_min,
    output logic [DW-1:0]    amplitude,
    output logic             locked,
    output logic             timeout
);

    localparam logic [DW-1:0]    MID_V = DW'(MID);
    localparam logic [DW-1:0]    ARM_V = DW'(MID - HYST);
    localparam logic [CNT_W:0]   TOL_V = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DW-1:0]      run_max_reg, run_min_reg;
    logic [CNT_W-1:0]   prev_period_reg;
    logic               have_prev_reg;
    logic               out_valid_reg, timeout_reg, locked_reg;
    logic [CNT_W-1:0]   period_reg;
    logic [DW-1:0]      peak_max_reg, peak_min_reg, amplitude_reg;

    logic               accept, sample_high, sample_low, cnt_full;
    logic               cross_first, cross_meas, to_hit, count_en;
    logic [DW:0]        span;
    logic [DW-1:0]      amplitude_next;
    logic [CNT_W:0]     pdiff, pdiff_abs;
    logic               period_match;

    // clr wins over a simultaneous sample, which is then discarded
    assign accept      = in_valid && !clr;
    assign sample_high = (in_sample >= MID_V);
    assign sample_low  = (in_sample < ARM_V);
    assign cnt_full    = (cnt_reg == {CNT_W{1'b1}});

    assign span           = {1'b0, run_max_reg} - {1'b0, run_min_reg};
    assign amplitude_next = DW'(span >> 1);

    assign pdiff        = {1'b0, cnt_reg} - {1'b0, prev_period_reg};
    assign pdiff_abs    = pdiff[CNT_W] ? (~pdiff + 1'b1) : pdiff;
    assign period_match = have_prev_reg && (pdiff_abs <= TOL_V);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Event decode for the accepted sample
    always_comb begin
        cross_first = 1'b0;
        cross_meas  = 1'b0;
        to_hit      = 1'b0;
        count_en    = 1'b0;
        if (accept) begin
            unique case (state_reg)
                ARM: begin
                    if (sample_high)   cross_first = 1'b1;
                    else if (cnt_full) to_hit      = 1'b1;
                end
                HIGH: begin
                    if (cnt_full) to_hit   = 1'b1;
                    else          count_en = 1'b1;
                end
                LOW: begin
                    if (sample_high)   cross_meas = 1'b1;
                    else if (cnt_full) to_hit     = 1'b1;
                    else               count_en   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (clr || to_hit) begin
            state_next = IDLE;
        end else if (cross_first || cross_meas) begin
            state_next = HIGH;
        end else if (accept) begin
            unique case (state_reg)
                IDLE:    if (sample_low) state_next = ARM;
                HIGH:    if (sample_low) state_next = LOW;
                default: ;
            endcase
        end
    end

    // Measurement datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            run_max_reg     <= '0;
            run_min_reg     <= '0;
            prev_period_reg <= '0;
            have_prev_reg   <= 1'b0;
            out_valid_reg   <= 1'b0;
            timeout_reg     <= 1'b0;
            locked_reg      <= 1'b0;
            period_reg      <= '0;
            peak_max_reg    <= '0;
            peak_min_reg    <= '0;
            amplitude_reg   <= '0;
        end else if (clr) begin
            cnt_reg         <= '0;
            run_max_reg     <= '0;
            run_min_reg     <= '0;
            prev_period_reg <= '0;
            have_prev_reg   <= 1'b0;
            out_valid_reg   <= 1'b0;
            timeout_reg     <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            out_valid_reg <= cross_meas;
            timeout_reg   <= to_hit;

            // The crossing sample opens the new period
            if (cross_first || cross_meas) begin
                cnt_reg     <= CNT_W'(1);
                run_max_reg <= in_sample;
                run_min_reg <= in_sample;
            end else if (count_en) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (in_sample > run_max_reg) run_max_reg <= in_sample;
                if (in_sample < run_min_reg) run_min_reg <= in_sample;
            end else if (to_hit) begin
                cnt_reg <= '0;
            end

            if (cross_meas) begin
                period_reg      <= cnt_reg;
                peak_max_reg    <= run_max_reg;
                peak_min_reg    <= run_min_reg;
                amplitude_reg   <= amplitude_next;
                locked_reg      <= period_match;
                prev_period_reg <= cnt_reg;
                have_prev_reg   <= 1'b1;
            end

            if (to_hit) begin
                locked_reg    <= 1'b0;
                have_prev_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign timeout   = timeout_reg;
    assign locked    = locked_reg;
    assign period    = period_reg;
    assign peak_max  = peak_max_reg;
    assign peak_min  = peak_min_reg;
    assign amplitude = amplitude_reg;

endmodule

// File: tb/tb_sine_wave_analyzer.sv
// Directed bench for sine_wave_analyzer: generator loop, gaps, noise, period step, timeout, reset/clear.
module tb_sine_wave_analyzer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_sample;

    logic        out_valid, locked, timeout;
    logic [11:0] period;
    logic [15:0] peak_max, peak_min, amplitude;

    logic        out_valid4, locked4, timeout4;
    logic [3:0]  period4;
    logic [15:0] peak_max4, peak_min4, amplitude4;

    int n_assert = 0;
    int n_fail   = 0;
    int ov_cnt   = 0;
    int ov4_cnt  = 0;

    // round(1000*sin(2*pi*k/64)), k = 0..16
    int q_tab [17] = '{0, 98, 195, 290, 383, 471, 556, 634, 707, 773, 831, 882, 924, 957, 981, 995, 1000};
    int hyst_seq [8] = '{900, 1000, 980, 1010, 960, 1000, 900, 1000};
    int lock_seq [6] = '{900, 1000, 900, 1000, 900, 1000};

    always #5 clk = ~clk;

    sine_wave_analyzer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .out_valid (out_valid),
        .period    (period),
        .peak_max  (peak_max),
        .peak_min  (peak_min),
        .amplitude (amplitude),
        .locked    (locked),
        .timeout   (timeout)
    );

    sine_wave_analyzer #(.CNT_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .out_valid (out_valid4),
        .period    (period4),
        .peak_max  (peak_max4),
        .peak_min  (peak_min4),
        .amplitude (amplitude4),
        .locked    (locked4),
        .timeout   (timeout4)
    );

    function automatic int gen(input int t);
        int p;
        p = t % 64;
        if (p <= 16)      return 1000 + q_tab[p];
        else if (p <= 32) return 1000 + q_tab[32 - p];
        else if (p <= 48) return 1000 - q_tab[p - 32];
        else              return 1000 - q_tab[64 - p];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_assert++;
        assert (obs === expd)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
        end
    endtask

    task automatic step(input logic v, input int s);
        in_valid  = v;
        in_sample = 16'(s);
        @(posedge clk);
        #1;
        if (out_valid)  ov_cnt++;
        if (out_valid4) ov4_cnt++;
        $display("step valid=%0b sample=%0d -> ov=%0b period=%0d max=%0d min=%0d amp=%0d lock=%0b to=%0b | ov4=%0b p4=%0d lock4=%0b to4=%0b",
                 v, s, out_valid, period, peak_max, peak_min, amplitude, locked, timeout,
                 out_valid4, period4, locked4, timeout4);
    endtask

    task automatic do_clr();
        clr      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_period",    period,    0);
        chk("rst_peak_max",  peak_max,  0);
        chk("rst_amplitude", amplitude, 0);
        chk("rst_locked",    locked,    0);
        chk("rst_timeout",   timeout,   0);
        rst_n = 1'b1;

        // Continuous generator: crossings at t=64 (first), 128, 192
        ov_cnt = 0;
        for (int t = 0; t <= 192; t++) begin
            step(1'b1, gen(t));
            if (t == 64) chk("gen_first_cross_no_valid", out_valid, 0);
            if (t == 128) begin
                chk("gen128_valid",  out_valid, 1);
                chk("gen128_period", period,    64);
                chk("gen128_max",    peak_max,  2000);
                chk("gen128_min",    peak_min,  0);
                chk("gen128_amp",    amplitude, 1000);
                chk("gen128_locked", locked,    0);
            end
            if (t == 192) begin
                chk("gen192_valid",  out_valid, 1);
                chk("gen192_period", period,    64);
                chk("gen192_locked", locked,    1);
            end
        end
        chk("gen_report_count", ov_cnt, 2);
        step(1'b1, gen(193));
        chk("gen_valid_pulse_drops", out_valid, 0);

        // Gapped input: every other cycle invalid
        do_clr();
        chk("clr_drops_lock",   locked, 0);
        chk("clr_holds_period", period, 64);
        ov_cnt = 0;
        for (int t = 0; t <= 192; t++) begin
            step(1'b1, gen(t));
            if (t == 128) chk("gap128_locked", locked, 0);
            if (t == 192) begin
                chk("gap192_valid",  out_valid, 1);
                chk("gap192_period", period,    64);
                chk("gap192_locked", locked,    1);
            end
            step(1'b0, 0);
        end
        chk("gap_report_count", ov_cnt, 2);

        // Noise around the midline
        do_clr();
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, hyst_seq[i]);
        end
        chk("hyst_valid",      out_valid, 1);
        chk("hyst_period",     period,    6);
        chk("hyst_max",        peak_max,  1010);
        chk("hyst_min",        peak_min,  900);
        chk("hyst_amp",        amplitude, 55);
        chk("hyst_locked",     locked,    0);
        chk("hyst_report_cnt", ov_cnt,    1);

        // Period step from 64 to 32 samples
        do_clr();
        ov_cnt = 0;
        for (int t = 0; t <= 192; t++) step(1'b1, gen(t));
        for (int t = 194; t <= 320; t += 2) begin
            step(1'b1, gen(t));
            if (t == 256) begin
                chk("pc256_valid",  out_valid, 1);
                chk("pc256_period", period,    32);
                chk("pc256_max",    peak_max,  2000);
                chk("pc256_min",    peak_min,  0);
                chk("pc256_locked", locked,    0);
            end
            if (t == 320) begin
                chk("pc320_period", period, 32);
                chk("pc320_locked", locked, 1);
            end
        end
        chk("pc_report_count", ov_cnt, 4);

        // Asynchronous reset mid-period
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_period",    period,    0);
        chk("arst_peak_max",  peak_max,  0);
        chk("arst_amplitude", amplitude, 0);
        chk("arst_locked",    locked,    0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // clr on a crossing sample
        for (int t = 0; t <= 255; t++) step(1'b1, gen(t));
        chk("pre_clr_locked", locked, 1);
        clr       = 1'b1;
        in_valid  = 1'b1;
        in_sample = 16'(gen(256));
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clrx_no_valid", out_valid, 0);
        chk("clrx_locked",   locked,    0);
        chk("clrx_period",   period,    64);
        chk("clrx_max",      peak_max,  2000);
        chk("clrx_amp",      amplitude, 1000);
        ov_cnt = 0;
        for (int t = 257; t <= 320; t++) step(1'b1, gen(t));
        chk("clrx_idle_no_report", ov_cnt, 0);

        // Timeout on the narrow-counter instance
        do_clr();
        for (int i = 0; i < 6; i++) step(1'b1, lock_seq[i]);
        chk("to_pre_valid",  out_valid4, 1);
        chk("to_pre_period", period4,    2);
        chk("to_pre_locked", locked4,    1);
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, 1500);
            if (i == 14) chk("to_not_yet", timeout4, 0);
        end
        step(1'b1, 1500);
        chk("to_pulse",       timeout4, 1);
        chk("to_locked",      locked4,  0);
        chk("to_period_hold", period4,  2);
        step(1'b1, 1000);
        chk("to_pulse_drops", timeout4, 0);
        ov4_cnt = 0;
        step(1'b1, 900);
        step(1'b1, 1000);
        chk("to_idle_first_cross", ov4_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
